// File: rtl/display_pkg.sv
// Shared types for the 4-digit 7-segment scan controller.
// Also holds the leading-zero mask helper used when suppression is built in.
package display_pkg;

  localparam int NDIGITS = 4;

  typedef logic [3:0]              nibble_t;
  typedef logic [1:0]              digit_t;
  typedef nibble_t [NDIGITS-1:0]   disp_word_t;

  // Bit i set means digit i is a leading zero: it and every higher digit
  // are 0 with no decimal point. Digit 0 always stays lit.
  function automatic logic [NDIGITS-1:0] lead_zero_mask(input disp_word_t word,
                                                        input logic [NDIGITS-1:0] dpv);
    logic [NDIGITS-1:0] mask;
    logic               run;
    mask = '0;
    run  = 1'b1;
    for (int i = NDIGITS - 1; i >= 1; i--) begin
      run     = run && (word[i] == 4'h0) && !dpv[i];
      mask[i] = run;
    end
    return mask;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_decode2.sv
// 2-to-4 one-hot decoder turning the scan digit index into a raw digit enable.
module decode2
  import display_pkg::*;
(
  input  digit_t               sel,
  output logic [NDIGITS-1:0]   onehot
);

  always_comb begin
    onehot      = '0;
    onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 4-digit 7-segment scan controller with a double-buffered write port.
// Define DISPLAY_SCAN_LZS_EN to build in leading-zero suppression.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int DIV   = 5000,
  parameter int BLANK = 50
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [15:0]         wr_data,
  input  logic [3:0]          wr_dp,
  output logic [1:0]          digit,
  output logic [3:0]          ct,
  output logic [3:0]          num,
  output logic                dp,
  output logic                frame_start
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_C  = CNT_W'(BLANK);

  logic [CNT_W-1:0]     cnt;
  digit_t               digit_q;
  disp_word_t           active;
  logic [NDIGITS-1:0]   dp_active;
  disp_word_t           pend_word;
  logic [NDIGITS-1:0]   pend_dp;
  logic                 pending;

  logic [NDIGITS-1:0]   onehot;
  logic [NDIGITS-1:0]   lz_mask;
  logic                 slot_last;
  logic                 frame_last;
  logic                 transfer;
  logic                 accept;

  logic [NDIGITS-1:0]   ct_p1;
  nibble_t              num_p1;
  logic                 dp_p1;
  logic                 fs_p1;

  // Digit enable is dark while blanking, disabled, or suppressed.
  function automatic logic [NDIGITS-1:0] ct_gate(input logic [NDIGITS-1:0] raw,
                                                 input logic               run,
                                                 input logic               in_blank,
                                                 input logic               hidden);
    return (run && !in_blank && !hidden) ? raw : '0;
  endfunction

  decode2 u_decode2 (
    .sel    (digit_q),
    .onehot (onehot)
  );

`ifdef DISPLAY_SCAN_LZS_EN
  assign lz_mask = lead_zero_mask(active, dp_active);
`else
  assign lz_mask = '0;
`endif

  assign slot_last  = (cnt == CNT_LAST);
  assign frame_last = en && (digit_q == 2'd3) && slot_last;
  // Swapping while disabled is safe: nothing is on the display.
  assign transfer   = pending && (frame_last || !en);
  assign accept     = wr_valid && !pending;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt     <= '0;
      digit_q <= '0;
    end else if (en) begin
      if (slot_last) begin
        cnt     <= '0;
        digit_q <= digit_q + 2'd1;
      end else begin
        cnt     <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      active    <= '0;
      dp_active <= '0;
      pending   <= 1'b0;
    end else if (transfer) begin
      active    <= pend_word;
      dp_active <= pend_dp;
      pending   <= 1'b0;
    end else if (accept) begin
      pending   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pend_word <= disp_word_t'(wr_data);
      pend_dp   <= wr_dp;
    end
  end

  // Stage p1: registered pin outputs, one cycle behind cnt/digit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ct_p1  <= '0;
      num_p1 <= '0;
      dp_p1  <= 1'b0;
      fs_p1  <= 1'b0;
    end else begin
      ct_p1  <= ct_gate(onehot, en, cnt < BLANK_C, lz_mask[digit_q]);
      num_p1 <= active[digit_q];
      dp_p1  <= dp_active[digit_q];
      fs_p1  <= en && (digit_q == 2'd0) && (cnt == '0);
    end
  end

  assign ct          = ct_p1;
  assign num         = num_p1;
  assign dp          = dp_p1;
  assign frame_start = fs_p1;
  assign digit       = digit_q;
  assign wr_ready    = !pending;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl at DIV=8, BLANK=2: driver queues expectations, monitor compares.
module tb_display_scan_ctrl;

  localparam int DIV   = 8;
  localparam int BLANK = 2;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic [3:0]  wr_dp;
  logic [1:0]  digit;
  logic [3:0]  ct;
  logic [3:0]  num;
  logic        dp;
  logic        frame_start;

  display_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .wr_dp       (wr_dp),
    .digit       (digit),
    .ct          (ct),
    .num         (num),
    .dp          (dp),
    .frame_start (frame_start)
  );

  typedef struct packed {
    logic [3:0] ct;
    logic [3:0] num;
    logic       dp;
    logic       fs;
    logic [1:0] digit;
    logic       rdy;
  } exp_t;

  exp_t  q[$];
  int    checks = 0;
  int    errors = 0;
  string tname  = "reset";

  // Reference state of the controller
  int          m_cnt, m_digit;
  logic [15:0] m_active, m_pd;
  logic [3:0]  m_dpa, m_pdp;
  logic        m_pend;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic hidden(input int d);
`ifdef DISPLAY_SCAN_LZS_EN
    if (d == 0) return 1'b0;
    return ((m_active >> (4 * d)) == 16'h0) && ((m_dpa >> d) == 4'h0);
`else
    return (d < 0);
`endif
  endfunction

  task automatic cyc(input logic rn, input logic e, input logic wv,
                     input logic [15:0] wd, input logic [3:0] wdp,
                     input bit use_hand = 1'b0, input exp_t he = '0);
    exp_t x;
    reset_n  = rn;
    en       = e;
    wr_valid = wv;
    wr_data  = wd;
    wr_dp    = wdp;
    @(posedge clk);
    x = '0;
    if (!rn) begin
      m_cnt = 0; m_digit = 0; m_active = 16'h0; m_dpa = 4'h0; m_pend = 1'b0;
    end else begin
      x.ct  = (e && m_cnt >= BLANK && !hidden(m_digit)) ? 4'(1 << m_digit) : 4'h0;
      x.num = 4'((m_active >> (4 * m_digit)) & 16'hF);
      x.dp  = m_dpa[m_digit];
      x.fs  = e && m_digit == 0 && m_cnt == 0;
      if (m_pend && (!e || (m_digit == 3 && m_cnt == DIV - 1))) begin
        m_active = m_pd; m_dpa = m_pdp; m_pend = 1'b0;
      end else if (wv && !m_pend) begin
        m_pd = wd; m_pdp = wdp; m_pend = 1'b1;
      end
      if (e) begin
        if (m_cnt == DIV - 1) begin
          m_cnt = 0; m_digit = (m_digit + 1) % 4;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end
    x.digit = 2'(m_digit);
    x.rdy   = !m_pend;
    #1;
    q.push_back(use_hand ? he : x);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
  endtask

  task automatic load_idle(input logic [15:0] d, input logic [3:0] p);
    cyc(1'b1, 1'b0, 1'b1, d, p);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({ct, num, dp, frame_start, digit, wr_ready} !== e) begin
        errors++;
        $display("FAIL %s t=%0t got ct=%b num=%h dp=%b fs=%b digit=%0d rdy=%b want ct=%b num=%h dp=%b fs=%b digit=%0d rdy=%b",
                 tname, $time, ct, num, dp, frame_start, digit, wr_ready,
                 e.ct, e.num, e.dp, e.fs, e.digit, e.rdy);
      end
    end
  end

  initial begin
    exp_t he;
    int   slot;
    logic pre;
    bit   took;
    reset_n = 1'b0; en = 1'b0; wr_valid = 1'b0; wr_data = 16'h0; wr_dp = 4'h0;
    m_cnt = 0; m_digit = 0; m_active = 16'h0; m_dpa = 4'h0; m_pend = 1'b0;
    m_pd = 16'h0; m_pdp = 4'h0;

    // Reset dominates live inputs
    tname = "reset";
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 16'hFFFF, 4'hF);

    // Load 4321 while disabled, then scan two frames against a hand-derived table
    tname = "load4321";
    load_idle(16'h4321, 4'h0);
    tname = "scan4321";
    for (int k = 0; k < 64; k++) begin
      slot     = (k / 8) % 4;
      he       = '0;
      he.ct    = ((k % 8) < BLANK) ? 4'h0 : 4'(1 << slot);
      he.num   = 4'(slot + 1);
      he.fs    = (k % 32) == 0;
      he.digit = 2'(((k + 1) / 8) % 4);
      he.rdy   = 1'b1;
      cyc(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 1'b1, he);
    end

    // Mid-frame write is held until the frame boundary
    tname = "midframe1234";
    run(10);
    cyc(1'b1, 1'b1, 1'b1, 16'h1234, 4'b0010);
    run(60);

    // Held valid is only taken once ready returns
    tname = "holdABCD";
    run(5);
    cyc(1'b1, 1'b1, 1'b1, 16'h5678, 4'h0);
    took = 1'b0;
    for (int i = 0; i < 80 && !took; i++) begin
      pre = m_pend;
      cyc(1'b1, 1'b1, 1'b1, 16'hABCD, 4'h0);
      if (!pre) took = 1'b1;
    end
    if (!took) begin
      errors++;
      $display("FAIL holdABCD accept bound expired got pending want accepted");
    end
    run(70);

    // Disable mid-slot: pending swaps in, scan freezes, then resumes
    tname = "enable_drop";
    run(3);
    cyc(1'b1, 1'b1, 1'b1, 16'h9876, 4'b0101);
    run(2);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
    run(40);

    // Reset with a write pending discards it
    tname = "reset_discard";
    cyc(1'b1, 1'b1, 1'b1, 16'h5555, 4'hF);
    run(3);
    cyc(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
    run(40);

    // Leading-zero patterns
    tname = "lz_0042";
    load_idle(16'h0042, 4'h0);
    run(34);
    tname = "lz_0000";
    load_idle(16'h0000, 4'h0);
    run(34);
    tname = "lz_0042_dp3";
    load_idle(16'h0042, 4'b1000);
    run(34);

    cyc(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
    @(negedge clk);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d queued want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
